// File: rtl/accumulate_kernel.sv
// Counted-loop accumulate kernel: folds i or i*i into an accumulator per cycle.
// Define ACCUM_SATURATE_EN for saturating arithmetic instead of wrapping.
module accumulate_kernel #(
    parameter int WIDTH = 64,
    parameter int LIMIT = 10,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_enable,
    input  logic [WIDTH-1:0] init_i,
    input  logic [WIDTH-1:0] init_acc,
    input  logic             mode,
    output logic             w_enable,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOOP, DONE} state_t;

    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0] STP = (WIDTH+1)'(STEP);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH:0]   i_q;
    logic [WIDTH-1:0] acc_q;
    logic             mode_q;
    logic             more;
    logic [WIDTH-1:0] i_low;
    logic [WIDTH-1:0] sq;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] acc_nxt;

    assign more  = i_q < LIM;
    assign i_low = i_q[WIDTH-1:0];
    assign term  = mode_q ? sq : i_low;

`ifdef ACCUM_SATURATE_EN
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;

    // Any overflow pins the value at all-ones; all-ones plus anything stays there.
    assign prod    = {{WIDTH{1'b0}}, i_low} * {{WIDTH{1'b0}}, i_low};
    assign sq      = (|prod[2*WIDTH-1:WIDTH]) ? '1 : prod[WIDTH-1:0];
    assign sum     = {1'b0, acc_q} + {1'b0, term};
    assign acc_nxt = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    assign sq      = i_low * i_low;
    assign acc_nxt = acc_q + term;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (r_enable) state_d = LOOP;
            LOOP:    if (!more) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_enable = (state_q == DONE);
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q    <= '0;
            acc_q  <= '0;
            mode_q <= 1'b0;
            result <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (r_enable) begin
                        i_q    <= {1'b0, init_i};
                        acc_q  <= init_acc;
                        mode_q <= mode;
                    end
                end
                LOOP: begin
                    if (more) begin
                        acc_q <= acc_nxt;
                        i_q   <= i_q + STP;
                    end else begin
                        result <= acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
